light_tracker: RTL and testbench



---
 rtl/light_tracker_pkg.sv | 17 +
 rtl/light_tracker_channel_averager.sv | 45 ++++
 rtl/light_tracker.sv | 139 +++++++++++++
 tb/tb_light_tracker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/light_tracker_pkg.sv
// Shared definitions for the sun-tracking decision stage and the servo stage
// that consumes its position code.
package light_tracker_pkg;

   localparam int SAMPLE_W = 12;

   localparam logic [11:0] POS_MIN = 12'd1;
   localparam logic [11:0] POS_CTR = 12'd2;
   localparam logic [11:0] POS_MAX = 12'd3;

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_COMPARE = 2'd1,
      ST_SETTLE  = 2'd2
   } lt_state_e;

endpackage

// File: rtl/light_tracker_channel_averager.sv
// One photosensor channel: saturating sample count with a power-of-two
// accumulator, a full flag and a truncated average.
module light_tracker_channel_averager
   import light_tracker_pkg::*;
#(
   parameter int AVG_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   input  logic                i_valid,
   input  logic [SAMPLE_W-1:0] i_data,
   output logic                o_full,
   output logic [SAMPLE_W-1:0] o_avg
);

   localparam int ACC_W = SAMPLE_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << AVG_LOG2;

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;

   assign w_full = (r_cnt == FULL_CNT);

   // Once the window is full, extra samples are ignored so the average
   // always reflects the first 2^AVG_LOG2 samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_valid && !w_full) begin
         r_acc <= r_acc + ACC_W'(i_data);
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_full = w_full;
   assign o_avg  = r_acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/light_tracker.sv
// Averages east/west photosensor samples, compares against a deadband and
// steps a saturating position code, then waits a settle interval after each move.
module light_tracker
   import light_tracker_pkg::*;
#(
   parameter int          AVG_LOG2   = 4,
   parameter logic [11:0] DEADBAND   = 12'd64,
   parameter logic [11:0] P_MIN      = POS_MIN,
   parameter logic [11:0] P_CTR      = POS_CTR,
   parameter logic [11:0] P_MAX      = POS_MAX,
   parameter logic [11:0] STEP       = 12'd1,
   parameter logic [23:0] SETTLE_CYC = 24'd12_500_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_valid,
   input  logic                sample_ch,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic                sample_ready,
   output logic [11:0]         pos,
   output logic                pos_valid,
   output logic                at_limit,
   output lt_state_e           o_dbg_state
);

   localparam logic signed [12:0] DB_POS = $signed({1'b0, DEADBAND});
   localparam logic signed [12:0] DB_NEG = -DB_POS;
   localparam logic signed [13:0] STEP_S = $signed({2'b00, STEP});
   localparam logic signed [13:0] MIN_S  = $signed({2'b00, P_MIN});
   localparam logic signed [13:0] MAX_S  = $signed({2'b00, P_MAX});

   lt_state_e           r_state;
   lt_state_e           w_next_state;
   logic [11:0]         r_pos;
   logic                r_pos_valid;
   logic                r_at_limit;
   logic                r_sample_ready;
   logic [23:0]         r_settle_cnt;

   logic                w_accept;
   logic                w_full_e, w_full_w;
   logic [SAMPLE_W-1:0] w_avg_e, w_avg_w;
   logic signed [12:0]  w_diff;
   logic                w_want_up, w_want_dn;
   logic signed [13:0]  w_pos_s, w_target;
   logic                w_in_range;
   logic                w_settle_done;
   logic                w_clear, w_move, w_block;

   assign w_accept = sample_valid && r_sample_ready;

   light_tracker_channel_averager #(.AVG_LOG2(AVG_LOG2)) u_avg_east (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_valid (w_accept && !sample_ch),
      .i_data  (sample_data),
      .o_full  (w_full_e),
      .o_avg   (w_avg_e)
   );

   light_tracker_channel_averager #(.AVG_LOG2(AVG_LOG2)) u_avg_west (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_valid (w_accept && sample_ch),
      .i_data  (sample_data),
      .o_full  (w_full_w),
      .o_avg   (w_avg_w)
   );

   // Target is formed with headroom so stepping past either end never wraps.
   assign w_diff        = $signed({1'b0, w_avg_e}) - $signed({1'b0, w_avg_w});
   assign w_want_up     = (w_diff > DB_POS);
   assign w_want_dn     = (w_diff < DB_NEG);
   assign w_pos_s       = $signed({2'b00, r_pos});
   assign w_target      = w_want_up ? (w_pos_s + STEP_S) : (w_pos_s - STEP_S);
   assign w_in_range    = (w_target >= MIN_S) && (w_target <= MAX_S);
   assign w_settle_done = (r_settle_cnt == SETTLE_CYC - 24'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_ACCUM;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      w_move       = 1'b0;
      w_block      = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_full_e && w_full_w) w_next_state = ST_COMPARE;
         end
         ST_COMPARE: begin
            if ((w_want_up || w_want_dn) && w_in_range) begin
               w_move       = 1'b1;
               w_next_state = ST_SETTLE;
            end else begin
               w_block      = w_want_up || w_want_dn;
               w_clear      = 1'b1;
               w_next_state = ST_ACCUM;
            end
         end
         ST_SETTLE: begin
            if (w_settle_done) begin
               w_clear      = 1'b1;
               w_next_state = ST_ACCUM;
            end
         end
         default: w_next_state = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pos          <= P_CTR;
         r_pos_valid    <= 1'b0;
         r_at_limit     <= 1'b0;
         r_sample_ready <= 1'b1;
         r_settle_cnt   <= '0;
      end else begin
         r_pos_valid    <= w_move;
         r_sample_ready <= (w_next_state == ST_ACCUM);
         if (w_move) r_pos <= w_target[11:0];
         if (w_move)       r_at_limit <= 1'b0;
         else if (w_block) r_at_limit <= 1'b1;
         if (r_state == ST_SETTLE && !w_settle_done) r_settle_cnt <= r_settle_cnt + 24'd1;
         else                                        r_settle_cnt <= '0;
      end
   end

   assign sample_ready = r_sample_ready;
   assign pos          = r_pos;
   assign pos_valid    = r_pos_valid;
   assign at_limit     = r_at_limit;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_light_tracker.sv
// Directed bench for light_tracker with a shortened settle interval.
module tb_light_tracker;
   import light_tracker_pkg::*;

   localparam int SETTLE = 20;

   logic        clk;
   logic        rst;
   logic        sample_valid;
   logic        sample_ch;
   logic [11:0] sample_data;
   logic        sample_ready;
   logic [11:0] pos;
   logic        pos_valid;
   logic        at_limit;
   lt_state_e   dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   light_tracker #(.SETTLE_CYC(24'(SETTLE))) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .pos          (pos),
      .pos_valid    (pos_valid),
      .at_limit     (at_limit),
      .o_dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
      else n_pass++;
   endtask

   task automatic send(input logic ch, input logic [11:0] data);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_ch    = ch;
      sample_data  = data;
   endtask

   task automatic send_window(input logic [11:0] e, input logic [11:0] w);
      for (int i = 0; i < 16; i++) begin
         send(1'b0, e);
         send(1'b1, w);
      end
   endtask

   // Called right after the window-completing sample was driven.
   task automatic observe(input string name, input int exp_pos, input bit exp_move,
                          input int exp_lim);
      int pulses = 0;
      int pulse_idx = -1;
      int low = 0;
      @(negedge clk);
      sample_valid = 1'b0;
      for (int i = 0; i < SETTLE + 12; i++) begin
         if (pos_valid === 1'b1) begin
            pulses++;
            pulse_idx = i;
         end
         if (sample_ready !== 1'b1) low++;
         @(negedge clk);
      end
      check({name, " pulses"}, pulses, exp_move ? 1 : 0);
      if (exp_move) check({name, " pulse_cycle"}, pulse_idx, 2);
      check({name, " ready_low_cycles"}, low, exp_move ? SETTLE + 1 : 1);
      check({name, " pos"}, int'(pos), exp_pos);
      check({name, " at_limit"}, int'(at_limit), exp_lim);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      sample_valid = 1'b0;
      sample_ch    = 1'b0;
      sample_data  = '0;
      rst          = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset pos", int'(pos), 2);
      check("reset pos_valid", int'(pos_valid), 0);
      check("reset at_limit", int'(at_limit), 0);
      check("reset sample_ready", int'(sample_ready), 1);
      check("reset state", int'(dbg_state), int'(ST_ACCUM));
   endtask

   task automatic test_move_east();
      send_window(12'd2000, 12'd1000);
      observe("east_move", 3, 1'b1, 0);
   endtask

   task automatic test_at_limit();
      send_window(12'd2000, 12'd1000);
      observe("blocked_max", 3, 1'b0, 1);
      send_window(12'd1000, 12'd2000);
      observe("west_move", 2, 1'b1, 0);
   endtask

   task automatic test_deadband();
      send_window(12'd1500, 12'd1464);
      observe("small_diff_a", 2, 1'b0, 0);
      send_window(12'd1500, 12'd1464);
      observe("small_diff_b", 2, 1'b0, 0);
      send_window(12'd1564, 12'd1500);
      observe("diff_plus64", 2, 1'b0, 0);
      send_window(12'd1500, 12'd1564);
      observe("diff_minus64", 2, 1'b0, 0);
      send_window(12'd1565, 12'd1500);
      observe("diff_plus65", 3, 1'b1, 0);
      send_window(12'd1500, 12'd1565);
      observe("diff_minus65", 2, 1'b1, 0);
      // Mixed samples: east avg (16*1000+16*1037)/32 is not used; per-channel
      // truncation: east 8x1000+8x1131 = 1065 (17048>>4), west 1000 -> diff 65.
      for (int i = 0; i < 16; i++) begin
         send(1'b0, (i < 8) ? 12'd1000 : 12'd1131);
         send(1'b1, 12'd1000);
      end
      observe("trunc_move", 3, 1'b1, 0);
      send_window(12'd1000, 12'd2000);
      observe("trunc_return", 2, 1'b1, 0);
   endtask

   task automatic test_channel_overflow();
      for (int i = 0; i < 16; i++) send(1'b0, 12'd1000);
      for (int i = 0; i < 4; i++)  send(1'b0, 12'd4000);
      for (int i = 0; i < 15; i++) send(1'b1, 12'd1000);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("overflow waits_for_west ready", int'(sample_ready), 1);
      check("overflow waits_for_west state", int'(dbg_state), int'(ST_ACCUM));
      send(1'b1, 12'd1000);
      observe("overflow_ignored", 2, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      send_window(12'd2000, 12'd1000);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_settle ready_low", int'(sample_ready), 0);
      check("mid_settle pos", int'(pos), 3);
      #2 rst = 1'b0;
      #1;
      check("async_reset pos", int'(pos), 2);
      check("async_reset pos_valid", int'(pos_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("after_settle_reset ready", int'(sample_ready), 1);
      check("after_settle_reset pos", int'(pos), 2);
      for (int i = 0; i < 10; i++) begin
         send(1'b0, 12'd4000);
         send(1'b1, 12'd0);
      end
      do_reset();
      check("after_accum_reset ready", int'(sample_ready), 1);
      check("after_accum_reset pos_valid", int'(pos_valid), 0);
      send_window(12'd1000, 12'd1000);
      observe("fresh_window", 2, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_move_east();
      test_at_limit();
      test_deadband();
      test_channel_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
